// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W     = 5;
   localparam int unsigned FSM_CNT_W = 4;

   // Execute operand source select
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // ResultSrcE encoding that marks a load
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Multi-cycle hold sequencer states
   typedef enum logic {
      HZ_IDLE = 1'b0,
      HZ_BUSY = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one Execute operand; Memory stage wins over Writeback.
module hazard_fwd_sel
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic             reg_write_m,
   input  logic [REG_W-1:0] rd_m,
   input  logic             reg_write_w,
   input  logic [REG_W-1:0] rd_w,
   output fwd_sel_t         sel
);

   // Priority select; x0 is never forwarded
   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: forwarding, load-use stall, branch flush,
// multi-cycle Execute hold and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULTI_LAT = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdE,
   input  logic             RegWriteE,
   input  logic [1:0]       ResultSrcE,
   input  logic             MultiE,
   input  logic             PCSrcE,
   input  logic             RegWriteM,
   input  logic [REG_W-1:0] RdM,
   input  logic             RegWriteW,
   input  logic [REG_W-1:0] RdW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             BubbleM,
   output logic [CNT_W-1:0] StallCount
);

   localparam logic [FSM_CNT_W-1:0] HOLD_LOAD = FSM_CNT_W'(MULTI_LAT - 2);

   hz_state_t             state, state_nxt;
   logic [FSM_CNT_W-1:0]  cnt, cnt_nxt;
   logic                  mc_stall;
   logic                  lw_stall;
   fwd_sel_t              fwd_a, fwd_b;

   // Operand A and B forwarding selects
   hazard_fwd_sel u_fwd_a (
      .rs          (Rs1E),
      .reg_write_m (RegWriteM),
      .rd_m        (RdM),
      .reg_write_w (RegWriteW),
      .rd_w        (RdW),
      .sel         (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .rs          (Rs2E),
      .reg_write_m (RegWriteM),
      .rd_m        (RdM),
      .reg_write_w (RegWriteW),
      .rd_w        (RdW),
      .sel         (fwd_b)
   );

   assign ForwardAE = fwd_a;
   assign ForwardBE = fwd_b;

   // Sequencer state and hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HZ_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and multi-cycle stall; a taken branch pre-empts entry
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mc_stall  = 1'b0;
      case (state)
         HZ_IDLE: begin
            if (MultiE && !PCSrcE) begin
               mc_stall  = 1'b1;
               cnt_nxt   = HOLD_LOAD;
               state_nxt = HZ_BUSY;
            end
         end
         HZ_BUSY: begin
            if (cnt != '0) begin
               mc_stall = 1'b1;
               cnt_nxt  = cnt - FSM_CNT_W'(1);
            end else begin
               state_nxt = HZ_IDLE;
            end
         end
         default: state_nxt = HZ_IDLE;
      endcase
   end

   // Load-use detection against the load sitting in Execute
   always_comb begin
      lw_stall = RegWriteE && (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
   end

   // Stall/flush equations; the held Execute op is never flushed, reset forces all low
   always_comb begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      BubbleM = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      if (rst_n) begin
         StallF  = lw_stall | mc_stall;
         StallD  = lw_stall | mc_stall;
         StallE  = mc_stall;
         BubbleM = mc_stall;
         FlushD  = PCSrcE & ~mc_stall;
         FlushE  = (lw_stall | PCSrcE) & ~mc_stall;
      end
   end

   // Saturating count of fetch-stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCount <= '0;
      end else if (StallF && (StallCount != '1)) begin
         StallCount <= StallCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MULTI_LAT=4/CNT_W=16 and MULTI_LAT=2/CNT_W=4)
// driven in lockstep and compared against a cycles-remaining reference model.
module tb_hazard_ctrl;

   localparam int unsigned LAT0 = 4;
   localparam int unsigned LAT1 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       reg_write_e, reg_write_m, reg_write_w, multi_e, pcsrc_e;
   logic [1:0] result_src_e;

   logic [1:0] fa [2];
   logic [1:0] fb [2];
   logic       sf [2];
   logic       sd [2];
   logic       se [2];
   logic       fd [2];
   logic       fe [2];
   logic       bm [2];
   logic [15:0] sc0;
   logic [3:0]  sc1;

   hazard_ctrl #(.MULTI_LAT(LAT0), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e),
      .RdE(rd_e), .RegWriteE(reg_write_e), .ResultSrcE(result_src_e), .MultiE(multi_e),
      .PCSrcE(pcsrc_e), .RegWriteM(reg_write_m), .RdM(rd_m), .RegWriteW(reg_write_w),
      .RdW(rd_w), .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
      .StallE(se[0]), .FlushD(fd[0]), .FlushE(fe[0]), .BubbleM(bm[0]), .StallCount(sc0)
   );

   hazard_ctrl #(.MULTI_LAT(LAT1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e),
      .RdE(rd_e), .RegWriteE(reg_write_e), .ResultSrcE(result_src_e), .MultiE(multi_e),
      .PCSrcE(pcsrc_e), .RegWriteM(reg_write_m), .RdM(rd_m), .RegWriteW(reg_write_w),
      .RdW(rd_w), .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
      .StallE(se[1]), .FlushD(fd[1]), .FlushE(fe[1]), .BubbleM(bm[1]), .StallCount(sc1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: cycles the multi-cycle op still has in Execute, and stall counts
   int left [2];
   int mcnt [2];
   int lat  [2] = '{LAT0, LAT1};
   int cmax [2] = '{65535, 15};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic lw_exp();
      return reg_write_e && result_src_e == 2'b01 && rd_e != 5'd0 &&
             (rd_e == rs1_d || rd_e == rs2_d);
   endfunction

   function automatic logic mc_exp(input int i);
      return (left[i] > 1) || (left[i] == 0 && multi_e && !pcsrc_e);
   endfunction

   task automatic check_all();
      logic lw, mc, br;
      for (int i = 0; i < 2; i++) begin
         lw = rst_n && lw_exp();
         mc = rst_n && mc_exp(i);
         br = rst_n && pcsrc_e;
         check_eq($sformatf("fwdA%0d", i), 32'(fa[i]), 32'(fwd_exp(rs1_e)));
         check_eq($sformatf("fwdB%0d", i), 32'(fb[i]), 32'(fwd_exp(rs2_e)));
         check_eq($sformatf("stallF%0d", i), 32'(sf[i]), 32'(lw | mc));
         check_eq($sformatf("stallD%0d", i), 32'(sd[i]), 32'(lw | mc));
         check_eq($sformatf("stallE%0d", i), 32'(se[i]), 32'(mc));
         check_eq($sformatf("bubbleM%0d", i), 32'(bm[i]), 32'(mc));
         check_eq($sformatf("flushD%0d", i), 32'(fd[i]), 32'(br & ~mc));
         check_eq($sformatf("flushE%0d", i), 32'(fe[i]), 32'((lw | br) & ~mc));
      end
      check_eq("count0", 32'(sc0), 32'(mcnt[0]));
      check_eq("count1", 32'(sc1), 32'(mcnt[1]));
   endtask

   // Advance one clock edge and update the model with the inputs held across it
   task automatic tick();
      logic stall;
      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            stall = lw_exp() || mc_exp(i);
            if (stall && mcnt[i] < cmax[i]) mcnt[i]++;
            if (left[i] == 0) begin
               if (multi_e && !pcsrc_e) left[i] = lat[i] - 1;
            end else begin
               left[i] = left[i] - 1;
            end
         end
      end
      #1;
   endtask

   task automatic model_reset();
      left = '{0, 0};
      mcnt = '{0, 0};
   endtask

   task automatic clear_inputs();
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
      reg_write_e = 0; reg_write_m = 0; reg_write_w = 0; multi_e = 0; pcsrc_e = 0;
      result_src_e = '0;
   endtask

   task automatic set_load_use();
      reg_write_e = 1; result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
   endtask

   int saved;

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Forwarding priority
      rd_m = 5'd5; rd_w = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5; reg_write_m = 1; reg_write_w = 1;
      #2; check_all(); check_eq("fwd_mem_prio", 32'(fa[0]), 32'd2);
      tick();
      rd_m = 5'd0;
      #2; check_all(); check_eq("fwd_wb", 32'(fa[0]), 32'd1);
      tick();
      rd_m = 5'd5; rs1_e = 5'd0;
      #2; check_all(); check_eq("fwd_x0", 32'(fa[0]), 32'd0); check_eq("fwd_b_mem", 32'(fb[0]), 32'd2);
      tick();
      clear_inputs();

      // Load-use: one stall cycle
      saved = mcnt[0];
      set_load_use();
      #2; check_all();
      check_eq("lu_stallF", 32'(sf[0]), 32'd1); check_eq("lu_flushE", 32'(fe[0]), 32'd1);
      tick();
      clear_inputs();
      #2; check_all(); check_eq("lu_release", 32'(sf[0]), 32'd0);
      check_eq("lu_count", 32'(sc0), 32'(saved + 1));
      tick();

      // Taken branch: flush only, no stall
      saved = mcnt[0];
      pcsrc_e = 1;
      #2; check_all();
      check_eq("br_flushD", 32'(fd[0]), 32'd1); check_eq("br_flushE", 32'(fe[0]), 32'd1);
      check_eq("br_stall", 32'(sf[0]), 32'd0);
      tick();
      pcsrc_e = 0;
      #2; check_all(); check_eq("br_flush_off", 32'(fd[0]), 32'd0);
      check_eq("br_count", 32'(sc0), 32'(saved));
      tick();

      // Multi-cycle hold with a load-use match in Decode during the hold
      saved = mcnt[0];
      for (int k = 0; k < 4; k++) begin
         multi_e = 1;
         if (k < 3) set_load_use(); else begin reg_write_e = 0; result_src_e = '0; end
         #2; check_all();
         check_eq($sformatf("mc_stallE_k%0d", k), 32'(se[0]), (k < 3) ? 32'd1 : 32'd0);
         check_eq($sformatf("mc_stallF_k%0d", k), 32'(sf[0]), (k < 3) ? 32'd1 : 32'd0);
         check_eq($sformatf("mc_flushE_k%0d", k), 32'(fe[0]), 32'd0);
         tick();
      end
      clear_inputs();
      #2; check_all(); check_eq("mc_idle", 32'(sf[0]), 32'd0);
      check_eq("mc_count", 32'(sc0), 32'(saved + 3));
      tick();

      // Reset while BUSY with cnt=1
      multi_e = 1;
      #2; check_all(); tick();
      #2; check_all(); tick();
      rst_n = 1'b0;
      model_reset();
      #1; check_all();
      check_eq("rst_stallF", 32'(sf[0]), 32'd0); check_eq("rst_bubble", 32'(bm[0]), 32'd0);
      check_eq("rst_count", 32'(sc0), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      multi_e = 0;
      #2; check_all(); check_eq("rst_after", 32'(sf[0]), 32'd0);
      tick();

      // Saturation of the 4-bit counter
      set_load_use();
      repeat (20) begin
         #2; check_all(); tick();
      end
      #2; check_all(); check_eq("sat15", 32'(sc1), 32'd15);
      tick();
      #2; check_eq("sat_hold", 32'(sc1), 32'd15);
      tick();
      clear_inputs();

      // Randomised traffic with occasional asynchronous reset
      repeat (400) begin
         rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
         rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
         rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
         rd_w  = 5'($urandom_range(0, 3));
         reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
         result_src_e = 2'($urandom);
         multi_e = ($urandom_range(0, 3) == 0);
         pcsrc_e = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1; check_all();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else begin
            #2; check_all();
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and sequencing controller for the five-stage pipelined RV32I core. It drives the stall, flush and bubble controls of the F/D/E/M pipeline registers, and the operand forwarding selects for the Execute stage. It owns a small FSM that holds the Execute stage for a fixed number of cycles while a multi-cycle ALU operation completes. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MULTI_LAT, 4, total cycles a multi-cycle op occupies Execute; legal range 2..16.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in Execute.
- RegWriteE  in  1  Execute instruction writes the register file.
- ResultSrcE  in  2  Execute result source; 2'b01 means load.
- MultiE  in  1  Execute instruction is a multi-cycle ALU op.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RegWriteM, RdM  in  1 / 5  Memory-stage writeback enable and destination.
- RegWriteW, RdW  in  1 / 5  Writeback-stage writeback enable and destination.
- ForwardAE, ForwardBE  out  2 each  SrcA/SrcB select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- StallF, StallD, StallE  out  1 each  hold the PC, the F/D register and the D/E register.
- FlushD, FlushE  out  1 each  clear the F/D and D/E registers on the next edge.
- BubbleM  out  1  load a bubble (all controls 0) into the E/M register.
- StallCount  out  CNT_W  saturating count of cycles with StallF=1.

## Operation
- **Forwarding** (combinational), shown for operand A; operand B is identical using Rs2E.
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - Memory stage has priority over Writeback.
- **Load-use**: lwStall = RegWriteE & ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- **FSM states**: IDLE, BUSY. The 4-bit register cnt resets to 0.
  - IDLE & MultiE & ~PCSrcE: mcStall=1; cnt<=MULTI_LAT-2; next state BUSY.
  - BUSY & cnt!=0: mcStall=1; cnt<=cnt-1.
  - BUSY & cnt==0: mcStall=0; next state IDLE. The op advances to Memory on this edge.
  - The op therefore spends exactly MULTI_LAT cycles in Execute.
- **Output equations**:
  - StallF = StallD = lwStall | mcStall.
  - StallE = BubbleM = mcStall.
  - FlushD = PCSrcE & ~mcStall.
  - FlushE = (lwStall | PCSrcE) & ~mcStall.
- **Simultaneous events**:
  - mcStall masks lwStall-driven and PCSrcE-driven flushes, so the held Execute op is never killed.
  - In IDLE, PCSrcE has priority over MultiE: flush, no FSM entry.
  - lwStall and PCSrcE together: FlushD=FlushE=1, StallF=StallD=1. The PC still loads the branch target, because the PC mux gives PCSrcE priority over StallF.
- **StallCount**: increments by 1 on each edge where StallF=1; holds at all-ones.
- **Reset**:
  - rst_n low forces state IDLE, cnt 0 and StallCount 0, and forces StallF/D/E, FlushD/E and BubbleM to 0.
  - ForwardAE/BE stay combinational and unaffected.
  - Reset mid-BUSY abandons the op immediately. The first cycle after release is IDLE.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state, and are valid in the same cycle.
- FSM state and cnt change only on the rising clk edge or asynchronously on the falling edge of rst_n.
- Load-use costs exactly 1 stall cycle: the next cycle, the load is in Memory and lwStall drops.
- A taken branch costs 2 cycles: the flushed Decode and Execute slots.
- A multi-cycle op costs MULTI_LAT-1 stall cycles.
- MULTI_LAT=2 gives one IDLE-stall cycle, then BUSY with cnt=0 and release.

## Structure
- Package hazard_pkg holds:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
  - constant RESULT_SRC_LOAD=2'b01;
  - enum hz_state_t {HZ_IDLE, HZ_BUSY}.
- Sub-module hazard_fwd_sel: purely combinational priority select for one operand, instantiated twice (A and B).
- FSM, counter and stall/flush equations live in hazard_ctrl.

## Test plan
- **Forwarding priority**: RdM=RdW=Rs1E=5, both RegWrite=1 -> ForwardAE=10. Same with RdM=0 -> 01. Rs1E=0 -> 00.
- **Load-use**: ResultSrcE=01, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCount +1.
- **Branch**: PCSrcE=1 for 1 cycle -> FlushD=FlushE=1 that cycle only; no stall; StallCount unchanged.
- **Multi-cycle, MULTI_LAT=4**: MultiE=1 held -> StallF/D/E=BubbleM=1 for 3 cycles, 0 on the 4th, FSM back in IDLE. A concurrent load-use match in Decode produces no FlushE during the hold. StallCount +3.
- **Reset mid-BUSY**: assert rst_n low with cnt=1 -> all stall/flush outputs 0 immediately, StallCount 0. After release with MultiE=0, no stall.
- **Saturation, CNT_W=4**: 20 consecutive stall cycles -> StallCount=15 and holds.
